// File: rtl/ofm_stream_tx_if.sv
// Feature-map drain bus: wide frame capture on the core side, word stream
// with valid/ready/last on the consumer side.
interface ofm_stream_tx_if #(
  parameter int WORD_W    = 20,
  parameter int NUM_WORDS = 35
);
  logic [WORD_W*NUM_WORDS-1:0] output_fm;
  logic                        load;
  logic [WORD_W-1:0]           tx_data;
  logic                        tx_valid;
  logic                        tx_ready;
  logic                        tx_last;
  logic                        busy;
  logic                        overrun;

  modport master (
    input  output_fm, load, tx_ready,
    output tx_data, tx_valid, tx_last, busy, overrun
  );

  modport slave (
    output output_fm, load, tx_ready,
    input  tx_data, tx_valid, tx_last, busy, overrun
  );
endinterface

// File: rtl/ofm_stream_tx.sv
// Captures one packed output feature map on load and streams it LSB word first
// over a valid/ready handshake, flagging the final word with tx_last.
module ofm_stream_tx #(
  parameter int WORD_W    = 20,
  parameter int NUM_WORDS = 35,
  parameter int CNT_W     = 6
) (
  input  logic           clk,
  input  logic           rst,
  ofm_stream_tx_if.master bus
);

  localparam int              FRAME_W  = WORD_W * NUM_WORDS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t             r_state;
  logic [FRAME_W-1:0] r_frame;
  logic [CNT_W-1:0]   r_idx;
  logic               r_tx_valid;
  logic               r_tx_last;
  logic               r_busy;
  logic               r_overrun;

  logic               w_xfer;
  logic [CNT_W-1:0]   w_next_idx;

  assign w_xfer     = r_tx_valid & bus.tx_ready;
  assign w_next_idx = r_idx + CNT_W'(1);

  // NOTE: all state, including the wide frame register, lives in one
  // always_ff with non-blocking assigns, so every output is a flop and
  // the async reset clears the whole datapath in one place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_frame    <= '0;
      r_idx      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      // A load during any busy cycle, including the final transfer, is dropped.
      if (bus.load && r_busy) r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            r_frame    <= bus.output_fm;
            r_idx      <= '0;
            r_tx_valid <= 1'b1;
            r_tx_last  <= (NUM_WORDS == 1);
            r_busy     <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            if (r_idx == LAST_IDX) begin
              r_frame    <= '0;
              r_idx      <= '0;
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              // Shifting keeps the current word at the LSB slice, which is
              // equivalent to selecting slice r_idx of the captured frame.
              r_frame   <= r_frame >> WORD_W;
              r_idx     <= w_next_idx;
              r_tx_last <= (w_next_idx == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

  assign bus.tx_data  = r_frame[WORD_W-1:0];
  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_last  = r_tx_last;
  assign bus.busy     = r_busy;
  assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_ofm_stream_tx.sv
// Randomized scoreboard bench for ofm_stream_tx: the driver queues expected
// words per accepted frame, a negedge monitor pops and compares each transfer.
module tb_ofm_stream_tx;

  localparam int WORD_W    = 20;
  localparam int NUM_WORDS = 35;
  localparam int CNT_W     = 6;
  localparam int FRAME_W   = WORD_W * NUM_WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ofm_stream_tx_if #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) bus ();

  ofm_stream_tx #(
    .WORD_W   (WORD_W),
    .NUM_WORDS(NUM_WORDS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    checks  = 0;
  int    errors  = 0;
  int    n_xfer  = 0;
  bit    exp_ovr = 1'b0;
  bit    bp_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame whose word i carries base + i.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [WORD_W-1:0] base);
    logic [FRAME_W-1:0] f;
    for (int i = 0; i < NUM_WORDS; i++) f[i*WORD_W +: WORD_W] = base + WORD_W'(i);
    return f;
  endfunction

  function automatic logic [FRAME_W-1:0] rand_frame();
    logic [FRAME_W-1:0] f;
    for (int i = 0; i < NUM_WORDS; i++) f[i*WORD_W +: WORD_W] = WORD_W'($urandom);
    return f;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  logic              prev_stall = 1'b0;
  logic [WORD_W-1:0] prev_data  = '0;
  logic              prev_last  = 1'b0;

  always @(negedge clk) begin : monitor
    beat_t b;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(bus.tx_valid), 32'd1);
        check("stall_data_held",  32'(bus.tx_data),  32'(prev_data));
        check("stall_last_held",  32'(bus.tx_last),  32'(prev_last));
      end
      if (!bus.tx_valid) check("last_without_valid", 32'(bus.tx_last), 32'd0);
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_xfer: got word 0x%0h, expected no transfer (t=%0t)",
                   bus.tx_data, $time);
        end else begin
          b = exp_q.pop_front();
          check("xfer_data", 32'(bus.tx_data), 32'(b.data));
          check("xfer_last", 32'(bus.tx_last), 32'(b.last));
        end
        n_xfer++;
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      prev_last  = bus.tx_last;
    end
  end

  // Downstream ready: held high, or random when backpressure is enabled.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Called just after a rising edge; returns just after the load edge.
  // Reference model: a load is taken only if no word of a frame is outstanding.
  task automatic load_frame(input logic [FRAME_W-1:0] fm);
    bit accept;
    accept = (exp_q.size() == 0);
    bus.output_fm = fm;
    bus.load      = 1'b1;
    if (accept) begin
      for (int i = 0; i < NUM_WORDS; i++)
        exp_q.push_back('{last: (i == NUM_WORDS - 1), data: fm[i*WORD_W +: WORD_W]});
    end else begin
      exp_ovr = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.load      = 1'b0;
    bus.output_fm = rand_frame();
    check("overrun_after_load", 32'(bus.overrun), 32'(exp_ovr));
    if (accept) begin
      check("busy_after_load",  32'(bus.busy),     32'd1);
      check("valid_after_load", 32'(bus.tx_valid), 32'd1);
    end
  endtask

  task automatic wait_drain(input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    check("busy_after_frame",  32'(bus.busy),     32'd0);
    check("valid_after_frame", 32'(bus.tx_valid), 32'd0);
  endtask

  task automatic wait_xfers(input int base, input int target, input int budget);
    int c = 0;
    while ((n_xfer - base) < target && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("xfer_progress", 32'(n_xfer - base), 32'(target));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"},   32'(bus.tx_valid), 32'd0);
    check({tag, "_busy"},    32'(bus.busy),     32'd0);
    check({tag, "_overrun"}, 32'(bus.overrun),  32'd0);
    check({tag, "_data"},    32'(bus.tx_data),  32'd0);
    check({tag, "_last"},    32'(bus.tx_last),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [FRAME_W-1:0] frame_a;
    logic [FRAME_W-1:0] frame_b;
    logic [FRAME_W-1:0] frame_ones;
    int cyc;
    int base;

    frame_a    = make_frame(20'h00001);
    frame_b    = make_frame(20'hA0000);
    frame_ones = '1;

    bus.load      = 1'b0;
    bus.output_fm = '0;

    // Reset and idle.
    #2;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_cleared("midcycle_reset");
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full-rate frame: one word per cycle.
    base = n_xfer;
    load_frame(frame_a);
    wait_drain(200, cyc);
    check("fullrate_cycles", 32'(cyc), 32'(NUM_WORDS));
    check("fullrate_count", 32'(n_xfer - base), 32'(NUM_WORDS));

    // Backpressure with random ready.
    bp_mode = 1'b1;
    base = n_xfer;
    load_frame(frame_a);
    wait_drain(4000, cyc);
    check("backpressure_count", 32'(n_xfer - base), 32'(NUM_WORDS));
    bp_mode = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // Overrun: all-ones load at word 10 and on the final transfer.
    check("overrun_initially_clear", 32'(bus.overrun), 32'd0);
    base = n_xfer;
    load_frame(frame_a);
    wait_xfers(base, 10, 100);
    load_frame(frame_ones);
    cyc = 0;
    while (exp_q.size() > 1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("final_word_pending", 32'(exp_q.size()), 32'd1);
    load_frame(frame_ones);
    check("busy_after_final_overrun", 32'(bus.busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("overrun_sticky", 32'(bus.overrun), 32'd1);
    check("overrun_count", 32'(n_xfer - base), 32'(NUM_WORDS));

    // Back-to-back frames: second load in the cycle after busy falls.
    base = n_xfer;
    load_frame(frame_a);
    wait_drain(200, cyc);
    load_frame(frame_b);
    wait_drain(200, cyc);
    check("b2b_count", 32'(n_xfer - base), 32'(2 * NUM_WORDS));

    // Reset after 12 transfers, then a clean frame from word 0.
    base = n_xfer;
    load_frame(frame_b);
    wait_xfers(base, 12, 100);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("frame_reset");
    exp_q.delete();
    exp_ovr = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    base = n_xfer;
    load_frame(frame_a);
    wait_drain(200, cyc);
    check("post_reset_count", 32'(n_xfer - base), 32'(NUM_WORDS));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
